// File: rtl/lc3_regfile_mp.sv
// lc3_regfile_mp: parametrised multi-port LC-3 register file with write-pending scoreboard and NZP.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle writeback forwarding to the read ports).
module lc3_regfile_mp #(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned NREGS  = 8,
  parameter  int unsigned NRD    = 2,
  localparam int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     LD_REG,
  input  logic [ADDR_W-1:0]        DR,
  input  logic [DATA_W-1:0]        D_IN,
  input  logic                     ISSUE,
  input  logic [ADDR_W-1:0]        ISSUE_DR,
  input  logic [NRD*ADDR_W-1:0]    RD_ADDR,
  output logic [NRD*DATA_W-1:0]    RD_DATA,
  output logic [NRD-1:0]           RD_BUSY,
  output logic [2:0]               NZP,
  output logic [NREGS-1:0]         PEND
);

  localparam logic [2:0] NZP_RST = 3'b010;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [2:0]        nzp_q, nzp_d;
  logic              din_neg, din_zero;

  assign din_neg  = D_IN[DATA_W-1];
  assign din_zero = (D_IN == '0);

  // Next state: a writeback retires the pending bit; a same-cycle issue re-reserves it.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    nzp_d  = nzp_q;
    if (LD_REG) begin
      regs_d[DR] = D_IN;
      pend_d[DR] = 1'b0;
      nzp_d      = {din_neg, din_zero, ~din_neg & ~din_zero};
    end
    if (ISSUE) begin
      pend_d[ISSUE_DR] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      nzp_q  <= NZP_RST;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      nzp_q  <= nzp_d;
    end
  end

  // Independent combinational read ports.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_c;
    logic              busy_c;

    assign addr = RD_ADDR[k*ADDR_W +: ADDR_W];

    always_comb begin
      data_c = regs_q[addr];
      busy_c = pend_q[addr];
`ifdef REGFILE_BYPASS_EN
      // A write discarded by reset must not be forwarded either.
      if (Reset_n && LD_REG && (DR == addr)) begin
        data_c = D_IN;
        busy_c = 1'b0;
      end
`endif
    end

    assign RD_DATA[k*DATA_W +: DATA_W] = data_c;
    assign RD_BUSY[k]                  = busy_c;
  end

  assign NZP  = nzp_q;
  assign PEND = pend_q;

endmodule

// File: tb/tb_lc3_regfile_mp.sv
// Scoreboard bench for lc3_regfile_mp: default 16/8/2 instance plus a 32/16/3 parameter sweep.
module tb_lc3_regfile_mp;

  localparam int unsigned DW  = 16;
  localparam int unsigned NR  = 8;
  localparam int unsigned NP  = 2;
  localparam int unsigned AW  = 3;
  localparam int unsigned WDW = 32;
  localparam int unsigned WNR = 16;
  localparam int unsigned WNP = 3;
  localparam int unsigned WAW = 4;

  typedef struct packed {
    logic [NP*DW-1:0] data;
    logic [NP-1:0]    busy;
    logic [NR-1:0]    pend;
    logic [2:0]       nzp;
  } exp_t;

  typedef struct packed {
    logic [WNP*WDW-1:0] data;
    logic [2:0]         nzp;
  } wexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance signals
  logic            ld = 1'b0, iss = 1'b0;
  logic [AW-1:0]   dr = '0, idr = '0;
  logic [DW-1:0]   din = '0;
  logic [NP*AW-1:0] rd_addr = '0;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]   rd_busy;
  logic [2:0]      nzp;
  logic [NR-1:0]   pend;

  // wide instance signals
  logic             wld = 1'b0, wiss = 1'b0;
  logic [WAW-1:0]   wdr = '0, widr = '0;
  logic [WDW-1:0]   wdin = '0;
  logic [WNP*WAW-1:0] wrd_addr = '0;
  logic [WNP*WDW-1:0] wrd_data;
  logic [WNP-1:0]   wrd_busy;
  logic [2:0]       wnzp;
  logic [WNR-1:0]   wpend;

  lc3_regfile_mp u_dut (
    .Clk(clk), .Reset_n(rst_n), .LD_REG(ld), .DR(dr), .D_IN(din),
    .ISSUE(iss), .ISSUE_DR(idr), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .RD_BUSY(rd_busy), .NZP(nzp), .PEND(pend)
  );

  lc3_regfile_mp #(.DATA_W(WDW), .NREGS(WNR), .NRD(WNP)) u_wide (
    .Clk(clk), .Reset_n(rst_n), .LD_REG(wld), .DR(wdr), .D_IN(wdin),
    .ISSUE(wiss), .ISSUE_DR(widr), .RD_ADDR(wrd_addr), .RD_DATA(wrd_data),
    .RD_BUSY(wrd_busy), .NZP(wnzp), .PEND(wpend)
  );

  // reference model: architectural state after the most recent edge
  logic [DW-1:0]  m_reg [NR];
  logic [NR-1:0]  m_pend;
  logic [2:0]     m_nzp;
  logic [WDW-1:0] m_wreg [WNR];
  logic [2:0]     m_wnzp;

  exp_t  exp_q[$];
  int    tag_q[$];
  wexp_t wexp_q[$];
  int    wtag_q[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  function automatic logic [2:0] flags_of(input logic neg, input logic zero);
    return {neg, zero, ~neg & ~zero};
  endfunction

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, t, act, want);
    end
  endtask

  // One cycle on the default instance; expectation describes outputs before the next edge.
  task automatic step(input logic r, input logic ld_i, input int dr_i, input logic [DW-1:0] d_i,
                      input logic iss_i, input int idr_i, input int a0, input int a1);
    exp_t e;
    int   a;
    logic [DW-1:0] d;
    logic b;
    @(posedge clk);
    #1;
    rst_n   = r;
    ld      = ld_i;
    dr      = AW'(dr_i);
    din     = d_i;
    iss     = iss_i;
    idr     = AW'(idr_i);
    rd_addr = {AW'(a1), AW'(a0)};
    for (int k = 0; k < int'(NP); k++) begin
      a = (k == 0) ? a0 : a1;
      d = m_reg[a];
      b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
      if (r && ld_i && dr_i == a) begin
        d = d_i;
        b = 1'b0;
      end
`endif
      if (!r) begin
        d = '0;
        b = 1'b0;
      end
      e.data[k*DW +: DW] = d;
      e.busy[k] = b;
    end
    e.pend = r ? m_pend : '0;
    e.nzp  = r ? m_nzp : 3'b010;
    exp_q.push_back(e);
    tag_q.push_back(cyc);
    cyc++;
    if (!r) begin
      for (int i = 0; i < int'(NR); i++) m_reg[i] = '0;
      m_pend = '0;
      m_nzp  = 3'b010;
      #5;
      rst_n = 1'b1;
      ld    = 1'b0;
      iss   = 1'b0;
    end else begin
      if (ld_i) begin
        m_reg[dr_i]  = d_i;
        m_pend[dr_i] = 1'b0;
        m_nzp        = flags_of(d_i[DW-1], d_i == '0);
      end
      if (iss_i) m_pend[idr_i] = 1'b1;
    end
  endtask

  // One cycle on the wide instance; reads are checked only when chk_en is set.
  task automatic wstep(input logic ld_i, input int dr_i, input logic [WDW-1:0] d_i,
                       input int a0, input int a1, input int a2, input logic chk_en);
    wexp_t e;
    @(posedge clk);
    #1;
    wld      = ld_i;
    wdr      = WAW'(dr_i);
    wdin     = d_i;
    wrd_addr = {WAW'(a2), WAW'(a1), WAW'(a0)};
    if (chk_en) begin
      e.data = {m_wreg[a2], m_wreg[a1], m_wreg[a0]};
      e.nzp  = m_wnzp;
      wexp_q.push_back(e);
      wtag_q.push_back(cyc);
    end
    cyc++;
    if (ld_i) begin
      m_wreg[dr_i] = d_i;
      m_wnzp       = flags_of(d_i[WDW-1], d_i == '0);
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      for (int k = 0; k < int'(NP); k++) begin
        chk($sformatf("rd_data[%0d]", k), t, 32'(rd_data[k*DW +: DW]), 32'(e.data[k*DW +: DW]));
        chk($sformatf("rd_busy[%0d]", k), t, 32'(rd_busy[k]), 32'(e.busy[k]));
      end
      chk("pend", t, 32'(pend), 32'(e.pend));
      chk("nzp", t, 32'(nzp), 32'(e.nzp));
    end
    if (wexp_q.size() > 0) begin
      wexp_t w;
      int t;
      w = wexp_q.pop_front();
      t = wtag_q.pop_front();
      for (int k = 0; k < int'(WNP); k++) begin
        chk($sformatf("wide_rd_data[%0d]", k), t, wrd_data[k*WDW +: WDW], w.data[k*WDW +: WDW]);
      end
      chk("wide_nzp", t, 32'(wnzp), 32'(w.nzp));
    end
  end

  initial begin
    logic [DW-1:0] rd;
    int ra;
    for (int i = 0; i < int'(NR); i++) m_reg[i] = '0;
    for (int i = 0; i < int'(WNR); i++) m_wreg[i] = '0;
    m_pend = '0;
    m_nzp  = 3'b010;
    m_wnzp = 3'b010;

    // reset state, then write/read with all three flag polarities
    step(1'b0, 1'b0, 0, 16'h0000, 1'b0, 0, 0, 7);
    step(1'b1, 1'b1, 3, 16'h8001, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 5, 16'h0000, 1'b0, 0, 3, 0);
    step(1'b1, 1'b1, 5, 16'h0007, 1'b0, 0, 5, 3);
    step(1'b1, 1'b0, 0, 16'h0000, 1'b0, 0, 5, 5);
    // scoreboard set, clear, and set-wins collision
    step(1'b1, 1'b0, 0, 16'h0000, 1'b1, 2, 0, 0);
    step(1'b1, 1'b0, 0, 16'h0000, 1'b0, 0, 2, 2);
    step(1'b1, 1'b1, 2, 16'h1234, 1'b0, 0, 2, 2);
    step(1'b1, 1'b0, 0, 16'h0000, 1'b0, 0, 2, 2);
    step(1'b1, 1'b1, 2, 16'h5555, 1'b1, 2, 2, 2);
    step(1'b1, 1'b0, 0, 16'h0000, 1'b0, 0, 2, 2);
    // write-to-read in the same cycle on port 1
    step(1'b1, 1'b1, 4, 16'h1111, 1'b1, 4, 0, 1);
    step(1'b1, 1'b1, 4, 16'h2222, 1'b0, 0, 0, 4);
    step(1'b1, 1'b0, 0, 16'h0000, 1'b0, 0, 0, 4);
    // reset pulse between edges while a write and issue are active
    step(1'b1, 1'b1, 6, 16'hbeef, 1'b1, 1, 6, 1);
    step(1'b0, 1'b1, 6, 16'hcafe, 1'b1, 6, 6, 3);
    step(1'b1, 1'b0, 0, 16'h0000, 1'b0, 0, 6, 3);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      rd = 16'($urandom());
      if ($urandom_range(0, 3) == 0) rd = '0;
      ra = int'($urandom_range(0, NR - 1));
      step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, NR - 1)), rd,
           1'($urandom_range(0, 1)), int'($urandom_range(0, NR - 1)),
           ra, ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, NR - 1)));
    end
    @(posedge clk);
    #1;
    ld  = 1'b0;
    iss = 1'b0;

    // wide instance: fill with index*0x0101, then read at distinct and identical addresses
    for (int i = 0; i < int'(WNR); i++) begin
      wstep(1'b1, i, 32'(i) * 32'h0101, 0, 0, 0, 1'b0);
    end
    for (int i = 0; i < int'(WNR); i++) begin
      wstep(1'b0, 0, '0, i, (i + 5) % 16, (i + 11) % 16, 1'b1);
      wstep(1'b0, 0, '0, i, i, i, 1'b1);
    end
    wstep(1'b0, 0, '0, 15, 0, 15, 1'b1);
    @(posedge clk);
    #1;
    wld = 1'b0;

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", cyc, 32'(exp_q.size() + wexp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
